vga_led_ctrl: RTL and testbench

Avalon-MM register slave that owns the eight 8-bit segment words feeding the seven-segment VGA emulator. Software writes shadow registers. The block commits them to the live hex0..hex7 outputs only at a frame boundary (VGA_VS assertion), so the display never tears mid-frame. It also schedules per-digit blinking on a frame-count basis and exposes commit status and a frame counter.

---
 rtl/vga_led_pkg.sv | 40 ++++
 rtl/vga_led_frame_timer.sv | 69 ++++++
 rtl/vga_led_ctrl.sv | 167 ++++++++++++++++
 tb/tb_vga_led_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_led_pkg.sv
// -----------------------------------------------------------------------------
// vga_led_pkg
// Purpose : shared register map, bit positions and types for the VGA
//           seven-segment controller slice.
// Contents: address constants, ctrl/status bit indices, seg_t, commit_state_t.
// -----------------------------------------------------------------------------
package vga_led_pkg;

   // Register map (4-bit Avalon word address)
   localparam logic [3:0] ADDR_DIG0   = 4'd0;
   localparam logic [3:0] ADDR_DIG1   = 4'd1;
   localparam logic [3:0] ADDR_DIG2   = 4'd2;
   localparam logic [3:0] ADDR_DIG3   = 4'd3;
   localparam logic [3:0] ADDR_DIG4   = 4'd4;
   localparam logic [3:0] ADDR_DIG5   = 4'd5;
   localparam logic [3:0] ADDR_DIG6   = 4'd6;
   localparam logic [3:0] ADDR_DIG7   = 4'd7;
   localparam logic [3:0] ADDR_BLINK  = 4'd8;
   localparam logic [3:0] ADDR_CTRL   = 4'd9;
   localparam logic [3:0] ADDR_STATUS = 4'd10;
   localparam logic [3:0] ADDR_FRAME  = 4'd11;

   // ctrl register bits
   localparam int CTRL_COMMIT = 0;
   localparam int CTRL_AUTO   = 1;

   // status register bits
   localparam int STAT_PENDING = 0;
   localparam int STAT_PHASE   = 1;

   // One segment word: bit0=a .. bit6=g, bit7=dp
   typedef logic [7:0] seg_t;

   // Commit sequencer: ARMED means a commit is pending for the next frame
   typedef enum logic {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } commit_state_t;

endpackage : vga_led_pkg

// File: rtl/vga_led_frame_timer.sv
// -----------------------------------------------------------------------------
// vga_led_frame_timer
// Purpose : detects the start of each VGA frame (falling edge of the active-low
//           vertical sync), counts frames and generates the blink phase.
// Ports   : clk50         - system clock
//           reset         - asynchronous, active-high reset
//           i_vga_vs      - VGA vertical sync, active low, synchronous to clk50
//           o_frame_tick  - one-cycle pulse in the cycle vga_vs is first seen low
//           o_frame_cnt   - 8-bit wrapping frame counter
//           o_phase       - blink phase (1 = digits on)
// -----------------------------------------------------------------------------
module vga_led_frame_timer #(
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic       clk50,
   input  logic       reset,
   input  logic       i_vga_vs,
   output logic       o_frame_tick,
   output logic [7:0] o_frame_cnt,
   output logic       o_phase
);

   localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

   logic       r_vs_q;
   logic       r_vs_valid;
   logic [7:0] r_frame_cnt;
   logic [7:0] r_blink_cnt;
   logic       r_phase;
   logic       w_frame_tick;

   // r_vs_valid suppresses the edge detector for the first clock after reset,
   // so a sync that is already low at reset release is not mistaken for a new
   // frame; the first tick then comes from the next genuine high-to-low edge.
   assign w_frame_tick = r_vs_valid & r_vs_q & ~i_vga_vs;

   // Sync edge detector, frame counter and blink half-period counter
   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         r_vs_q      <= 1'b1;
         r_vs_valid  <= 1'b0;
         r_frame_cnt <= 8'h00;
         r_blink_cnt <= 8'h00;
         r_phase     <= 1'b1;
      end else begin
         r_vs_q     <= i_vga_vs;
         r_vs_valid <= 1'b1;
         if (w_frame_tick) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
            if (r_blink_cnt == BLINK_LAST) begin
               r_blink_cnt <= 8'h00;
               r_phase     <= ~r_phase;
            end else begin
               r_blink_cnt <= r_blink_cnt + 8'd1;
               r_phase     <= r_phase;
            end
         end else begin
            r_frame_cnt <= r_frame_cnt;
            r_blink_cnt <= r_blink_cnt;
            r_phase     <= r_phase;
         end
      end
   end

   assign o_frame_tick = w_frame_tick;
   assign o_frame_cnt  = r_frame_cnt;
   assign o_phase      = r_phase;

endmodule : vga_led_frame_timer

// File: rtl/vga_led_ctrl.sv
// -----------------------------------------------------------------------------
// vga_led_ctrl
// Purpose : Avalon-MM slave owning eight shadow segment words. Shadow words are
//           copied to the live outputs only at a frame boundary so the display
//           never tears; per-digit blinking is scheduled on frame counts.
// Ports   : clk50, reset (async, active-high)
//           chipselect/write/read/address/writedata - Avalon slave inputs
//           readdata - registered read data, valid one cycle after read
//           vga_vs   - active-low VGA vertical sync
//           hex0..hex7 - live segment words to the emulator
// -----------------------------------------------------------------------------
module vga_led_ctrl
   import vga_led_pkg::*;
#(
   parameter int unsigned BLINK_FRAMES = 30,
   parameter seg_t        RESET_SEG    = 8'h00
) (
   input  logic       clk50,
   input  logic       reset,
   input  logic       chipselect,
   input  logic       write,
   input  logic       read,
   input  logic [3:0] address,
   input  logic [7:0] writedata,
   output logic [7:0] readdata,
   input  logic       vga_vs,
   output logic [7:0] hex0,
   output logic [7:0] hex1,
   output logic [7:0] hex2,
   output logic [7:0] hex3,
   output logic [7:0] hex4,
   output logic [7:0] hex5,
   output logic [7:0] hex6,
   output logic [7:0] hex7
);

   seg_t          r_shadow [8];
   seg_t          r_live   [8];
   logic [7:0]    r_blink_mask;
   logic          r_auto;
   commit_state_t r_state;
   logic [7:0]    r_readdata;

   logic          w_wr;
   logic          w_rd;
   logic          w_commit_wr;
   logic          w_pending;
   logic          w_commit;
   logic          w_frame_tick;
   logic [7:0]    w_frame_cnt;
   logic          w_phase;
   logic [7:0]    w_rd_mux;
   seg_t          w_hex [8];

   vga_led_frame_timer #(
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_frame_timer (
      .clk50        (clk50),
      .reset        (reset),
      .i_vga_vs     (vga_vs),
      .o_frame_tick (w_frame_tick),
      .o_frame_cnt  (w_frame_cnt),
      .o_phase      (w_phase)
   );

   assign w_wr        = chipselect & write;
   assign w_rd        = chipselect & read;
   assign w_commit_wr = w_wr & (address == ADDR_CTRL) & writedata[CTRL_COMMIT];
   assign w_pending   = (r_state == ARMED);
   // Auto-commit copies on every frame, independent of the sequencer state.
   assign w_commit    = w_frame_tick & (w_pending | r_auto);

   // Commit sequencer: a commit_req write coinciding with a tick keeps ARMED
   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_commit_wr) r_state <= ARMED;
               else             r_state <= IDLE;
            end
            ARMED: begin
               if (w_frame_tick && !w_commit_wr) r_state <= IDLE;
               else                              r_state <= ARMED;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Software-visible register bank: shadow digits, blink mask, auto_commit
   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         for (int n = 0; n < 8; n++) r_shadow[n] <= RESET_SEG;
         r_blink_mask <= 8'h00;
         r_auto       <= 1'b0;
      end else if (w_wr) begin
         case (address)
            ADDR_DIG0, ADDR_DIG1, ADDR_DIG2, ADDR_DIG3,
            ADDR_DIG4, ADDR_DIG5, ADDR_DIG6, ADDR_DIG7:
               r_shadow[address[2:0]] <= writedata;
            ADDR_BLINK: r_blink_mask <= writedata;
            ADDR_CTRL:  r_auto       <= writedata[CTRL_AUTO];
            default:    r_blink_mask <= r_blink_mask;
         endcase
      end else begin
         r_blink_mask <= r_blink_mask;
      end
   end

   // Live digits: non-blocking copy takes the pre-write shadow on a coincident write
   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         for (int n = 0; n < 8; n++) r_live[n] <= RESET_SEG;
      end else if (w_commit) begin
         r_live <= r_shadow;
      end else begin
         r_live <= r_live;
      end
   end

   // Read data multiplexer
   always_comb begin
      w_rd_mux = 8'h00;
      case (address)
         ADDR_DIG0, ADDR_DIG1, ADDR_DIG2, ADDR_DIG3,
         ADDR_DIG4, ADDR_DIG5, ADDR_DIG6, ADDR_DIG7:
            w_rd_mux = r_shadow[address[2:0]];
         ADDR_BLINK:  w_rd_mux = r_blink_mask;
         ADDR_CTRL:   w_rd_mux = {6'b000000, r_auto, w_pending};
         ADDR_STATUS: w_rd_mux = {6'b000000, w_phase, w_pending};
         ADDR_FRAME:  w_rd_mux = w_frame_cnt;
         default:     w_rd_mux = 8'h00;
      endcase
   end

   // Registered read data; holds its value between reads
   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         r_readdata <= 8'h00;
      end else if (w_rd) begin
         r_readdata <= w_rd_mux;
      end else begin
         r_readdata <= r_readdata;
      end
   end

   // Blanking of masked digits during the off half of the blink period
   always_comb begin
      for (int n = 0; n < 8; n++) begin
         if (r_blink_mask[n] && !w_phase) w_hex[n] = 8'h00;
         else                             w_hex[n] = r_live[n];
      end
   end

   assign readdata = r_readdata;
   assign hex0     = w_hex[0];
   assign hex1     = w_hex[1];
   assign hex2     = w_hex[2];
   assign hex3     = w_hex[3];
   assign hex4     = w_hex[4];
   assign hex5     = w_hex[5];
   assign hex6     = w_hex[6];
   assign hex7     = w_hex[7];

endmodule : vga_led_ctrl

// File: tb/tb_vga_led_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_led_ctrl
// Directed and randomized stimulus against a frame-level reference model:
// blink phase and frame count are derived arithmetically from the number of
// frame boundaries seen since reset.
// -----------------------------------------------------------------------------
module tb_vga_led_ctrl;

   localparam int BF = 2;

   logic       clk50;
   logic       reset;
   logic       chipselect;
   logic       write;
   logic       read;
   logic [3:0] address;
   logic [7:0] writedata;
   logic [7:0] readdata;
   logic       vga_vs;
   logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
   logic [7:0] hex_a [8];

   vga_led_ctrl #(
      .BLINK_FRAMES (BF),
      .RESET_SEG    (8'h00)
   ) dut (
      .clk50      (clk50),
      .reset      (reset),
      .chipselect (chipselect),
      .write      (write),
      .read       (read),
      .address    (address),
      .writedata  (writedata),
      .readdata   (readdata),
      .vga_vs     (vga_vs),
      .hex0       (hex0),
      .hex1       (hex1),
      .hex2       (hex2),
      .hex3       (hex3),
      .hex4       (hex4),
      .hex5       (hex5),
      .hex6       (hex6),
      .hex7       (hex7)
   );

   assign hex_a[0] = hex0;
   assign hex_a[1] = hex1;
   assign hex_a[2] = hex2;
   assign hex_a[3] = hex3;
   assign hex_a[4] = hex4;
   assign hex_a[5] = hex5;
   assign hex_a[6] = hex6;
   assign hex_a[7] = hex7;

   initial clk50 = 1'b0;
   always #10 clk50 = ~clk50;

   // ---------------- reference model state ----------------
   logic [7:0] m_shadow [8];
   logic [7:0] m_live   [8];
   logic [7:0] m_mask;
   logic       m_auto;
   logic       m_pend;
   logic       m_vs_high;   // sync seen high at the previous edge since reset
   logic [7:0] m_rd;
   int         m_ticks;     // frame boundaries since reset

   int n_cmp = 0;
   int n_mis = 0;

   function automatic logic m_phase();
      return ((m_ticks / BF) % 2) == 0;
   endfunction

   function automatic logic [7:0] m_hex(int n);
      return (m_mask[n] && !m_phase()) ? 8'h00 : m_live[n];
   endfunction

   function automatic logic [7:0] m_read(logic [3:0] a);
      if (a < 4'd8)        return m_shadow[a[2:0]];
      else if (a == 4'd8)  return m_mask;
      else if (a == 4'd9)  return {6'b000000, m_auto, m_pend};
      else if (a == 4'd10) return {6'b000000, m_phase(), m_pend};
      else if (a == 4'd11) return 8'(m_ticks % 256);
      else                 return 8'h00;
   endfunction

   task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int n = 0; n < 8; n++) check($sformatf("hex%0d", n), hex_a[n], m_hex(n));
      check("readdata", readdata, m_rd);
   endtask

   task automatic model_reset();
      for (int n = 0; n < 8; n++) begin
         m_shadow[n] = 8'h00;
         m_live[n]   = 8'h00;
      end
      m_mask    = 8'h00;
      m_auto    = 1'b0;
      m_pend    = 1'b0;
      m_vs_high = 1'b0;
      m_rd      = 8'h00;
      m_ticks   = 0;
   endtask

   // One clock with the currently driven inputs; model advances, then compare
   task automatic step();
      logic tick;
      logic cwr;
      tick = m_vs_high && !vga_vs;
      if (chipselect && read) m_rd = m_read(address);
      if (tick && (m_pend || m_auto)) begin
         for (int n = 0; n < 8; n++) m_live[n] = m_shadow[n];
      end
      cwr = chipselect && write && (address == 4'd9) && writedata[0];
      if (cwr)       m_pend = 1'b1;
      else if (tick) m_pend = 1'b0;
      if (tick) m_ticks++;
      if (chipselect && write) begin
         if (address < 4'd8)       m_shadow[address[2:0]] = writedata;
         else if (address == 4'd8) m_mask = writedata;
         else if (address == 4'd9) m_auto = writedata[1];
      end
      m_vs_high = vga_vs;
      @(posedge clk50);
      #1;
      check_all();
   endtask

   task automatic idle_bus();
      chipselect = 1'b0;
      write      = 1'b0;
      read       = 1'b0;
      address    = 4'd0;
      writedata  = 8'h00;
   endtask

   task automatic wr(logic [3:0] a, logic [7:0] d);
      chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
      step();
      idle_bus();
   endtask

   task automatic rd(logic [3:0] a);
      chipselect = 1'b1; write = 1'b0; read = 1'b1; address = a; writedata = 8'h00;
      step();
      idle_bus();
   endtask

   task automatic frame();
      vga_vs = 1'b0; step(); step();
      vga_vs = 1'b1; step(); step(); step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      check("rst_readdata", readdata, 8'h00);
      for (int n = 0; n < 8; n++) check($sformatf("rst_hex%0d", n), hex_a[n], 8'h00);
      @(posedge clk50);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      vga_vs = 1'b1;
      idle_bus();
      #3;
      do_reset();

      // Reset read-back of the whole map
      for (int a = 0; a < 12; a++) begin
         rd(4'(a));
         check("rst_rd", readdata, (a == 10) ? 8'h02 : 8'h00);
      end

      // Shadow write without commit stays invisible
      wr(4'd3, 8'h4F);
      frame(); frame(); frame();
      check("no_commit_h3", hex3, 8'h00);
      wr(4'd9, 8'h01);
      rd(4'd10);
      check("pend_set", {7'b0, readdata[0]}, 8'h01);
      vga_vs = 1'b0; step();
      check("commit_h3", hex3, 8'h4F);
      vga_vs = 1'b1;
      rd(4'd10);
      check("pend_clr", {7'b0, readdata[0]}, 8'h00);

      // commit_req in the exact cycle of a frame tick
      wr(4'd1, 8'h06);
      step();
      vga_vs = 1'b0;
      chipselect = 1'b1; write = 1'b1; address = 4'd9; writedata = 8'h01;
      step();
      idle_bus();
      check("coinc_h1_old", hex1, 8'h00);
      rd(4'd10);
      check("coinc_pend", {7'b0, readdata[0]}, 8'h01);
      vga_vs = 1'b1; step();
      vga_vs = 1'b0; step();
      check("coinc_h1_new", hex1, 8'h06);
      rd(4'd10);
      check("coinc_pend_clr", {7'b0, readdata[0]}, 8'h00);

      // Auto-commit
      vga_vs = 1'b1;
      wr(4'd9, 8'h02);
      wr(4'd0, 8'h3F);
      step(); step();
      check("auto_h0_wait", hex0, 8'h00);
      vga_vs = 1'b0; step();
      check("auto_h0", hex0, 8'h3F);
      vga_vs = 1'b1; step();

      // Blinking digit 5, digit 4 steady
      wr(4'd5, 8'h7F);
      wr(4'd4, 8'h66);
      wr(4'd8, 8'h20);
      for (int f = 0; f < 9; f++) begin
         frame();
         check("blink_h5", hex5, m_phase() ? 8'h7F : 8'h00);
         check("steady_h4", hex4, 8'h66);
      end

      // Reset mid-frame with pending set and sync low
      wr(4'd9, 8'h00);
      vga_vs = 1'b0; step();
      wr(4'd2, 8'h5B);
      wr(4'd9, 8'h01);
      rd(4'd10);
      check("pre_rst_pend", {7'b0, readdata[0]}, 8'h01);
      do_reset();
      step(); step();
      rd(4'd11);
      check("rst_frame_cnt", readdata, 8'h00);
      rd(4'd10);
      check("rst_status", readdata, 8'h02);
      vga_vs = 1'b1; step();
      vga_vs = 1'b0; step();
      rd(4'd11);
      check("first_tick", readdata, 8'h01);

      // Frame counter wrap: one tick every two cycles
      for (int f = 0; f < 260; f++) begin
         vga_vs = 1'b1; step();
         vga_vs = 1'b0; step();
      end
      rd(4'd11);
      check("frame_wrap", readdata, 8'(261 % 256));

      // Randomized traffic against the model
      for (int c = 0; c < 800; c++) begin
         chipselect = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 2))
            0: begin write = 1'b1; read = 1'b0; end
            1: begin write = 1'b0; read = 1'b1; end
            default: begin write = 1'b0; read = 1'b0; end
         endcase
         address   = 4'($urandom_range(0, 15));
         writedata = 8'($urandom);
         vga_vs    = ($urandom_range(0, 4) != 0);
         step();
      end
      idle_bus();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule : tb_vga_led_ctrl
